// File: rtl/dmux_4way.sv
// rtl/dmux_4way.sv - registered 1-to-4 demultiplexer with optional per-output hit counters (DMUX_4WAY_STATS_EN)
module dmux_4way #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    input  logic [1:0]           sel,
    input  logic                 clr_stats,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     c,
    output logic [WIDTH-1:0]     d,
    output logic [3:0]           out_valid,
    output logic [CNT_WIDTH-1:0] hit_cnt_a,
    output logic [CNT_WIDTH-1:0] hit_cnt_b,
    output logic [CNT_WIDTH-1:0] hit_cnt_c,
    output logic [CNT_WIDTH-1:0] hit_cnt_d
);

    logic [3:0] sel_onehot;
    logic [3:0] hit;

    // Decode select into a one-hot destination vector; sel is two bits so all cases are covered.
    always_comb begin
        sel_onehot = 4'b0000;
        case (sel)
            2'b00: sel_onehot = 4'b0001;
            2'b01: sel_onehot = 4'b0010;
            2'b10: sel_onehot = 4'b0100;
            2'b11: sel_onehot = 4'b1000;
        endcase
    end

    // A destination is hit only when the input word is qualified.
    assign hit = in_valid ? sel_onehot : 4'b0000;

    // Route the word to the selected output register and zero the other three.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            out_valid <= 4'b0000;
        end else begin
            a         <= hit[0] ? in : '0;
            b         <= hit[1] ? in : '0;
            c         <= hit[2] ? in : '0;
            d         <= hit[3] ? in : '0;
            out_valid <= hit;
        end
    end

`ifdef DMUX_4WAY_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt [4];

    // Saturating hit counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else if (clr_stats) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (hit[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign hit_cnt_a = cnt[0];
    assign hit_cnt_b = cnt[1];
    assign hit_cnt_c = cnt[2];
    assign hit_cnt_d = cnt[3];
`else
    logic unused_clr_stats;

    assign unused_clr_stats = clr_stats;
    assign hit_cnt_a        = '0;
    assign hit_cnt_b        = '0;
    assign hit_cnt_c        = '0;
    assign hit_cnt_d        = '0;
`endif

endmodule

// File: tb/tb_dmux_4way.sv
// tb/tb_dmux_4way.sv - directed self-checking bench for dmux_4way
module tb_dmux_4way;

    localparam int W  = 8;
    localparam int CW = 2;
`ifdef DMUX_4WAY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  din = '0;
    logic [1:0]    sel = 2'b00;
    logic          clr_stats = 1'b0;
    logic [W-1:0]  a, b, c, d;
    logic [3:0]    out_valid;
    logic [CW-1:0] hit_cnt_a, hit_cnt_b, hit_cnt_c, hit_cnt_d;

    int checks = 0;
    int failures = 0;

    dmux_4way #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (din),
        .sel       (sel),
        .clr_stats (clr_stats),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .hit_cnt_a (hit_cnt_a),
        .hit_cnt_b (hit_cnt_b),
        .hit_cnt_c (hit_cnt_c),
        .hit_cnt_d (hit_cnt_d)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr_stats = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        in_valid = 1'b1;
        din = 8'h01;
        sel = 2'b00;
        step();
        checks++;
        if (a !== 8'h01) begin
            failures++;
            $display("FAIL reset_pre_a got=%h exp=01", a);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a, b, c, d, out_valid} !== '0) begin
            failures++;
            $display("FAIL reset_async_outputs got=%h/%h/%h/%h/%b exp=0", a, b, c, d, out_valid);
        end
        checks++;
        if ({hit_cnt_a, hit_cnt_b, hit_cnt_c, hit_cnt_d} !== '0) begin
            failures++;
            $display("FAIL reset_async_counters got=%h exp=0", {hit_cnt_a, hit_cnt_b, hit_cnt_c, hit_cnt_d});
        end
        step();
        #2;
        rst_n = 1'b1;
        in_valid = 1'b1;
        din = 8'h5C;
        sel = 2'b01;
        step();
        checks++;
        if ({a, b, c, d, out_valid} !== {8'h00, 8'h5C, 8'h00, 8'h00, 4'b0010}) begin
            failures++;
            $display("FAIL reset_first_word got=%h/%h/%h/%h/%b exp=00/5c/00/00/0010", a, b, c, d, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_route_one();
        logic [W-1:0] exp_a, exp_b, exp_c, exp_d;
        logic [3:0]   exp_v;
        in_valid = 1'b1;
        din = 8'h01;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            step();
            exp_a = (i == 0) ? 8'h01 : 8'h00;
            exp_b = (i == 1) ? 8'h01 : 8'h00;
            exp_c = (i == 2) ? 8'h01 : 8'h00;
            exp_d = (i == 3) ? 8'h01 : 8'h00;
            exp_v = 4'b0001 << i;
            checks++;
            if ({a, b, c, d} !== {exp_a, exp_b, exp_c, exp_d}) begin
                failures++;
                $display("FAIL route_one_data sel=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", i, a, b, c, d, exp_a, exp_b, exp_c, exp_d);
            end
            checks++;
            if (out_valid !== exp_v) begin
                failures++;
                $display("FAIL route_one_valid sel=%0d got=%b exp=%b", i, out_valid, exp_v);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_zero_word();
        in_valid = 1'b1;
        din = 8'h00;
        sel = 2'b00;
        step();
        checks++;
        if ({a, b, c, d, out_valid} !== {32'h0, 4'b0001}) begin
            failures++;
            $display("FAIL zero_word got=%h/%h/%h/%h/%b exp=0/0/0/0/0001", a, b, c, d, out_valid);
        end
        in_valid = 1'b0;
        din = 8'hFF;
        sel = 2'b11;
        step();
        checks++;
        if ({a, b, c, d, out_valid} !== '0) begin
            failures++;
            $display("FAIL idle_cycle got=%h/%h/%h/%h/%b exp=0", a, b, c, d, out_valid);
        end
    endtask

    task automatic test_wide_word();
        in_valid = 1'b1;
        din = 8'hA5;
        sel = 2'b10;
        step();
        checks++;
        if ({a, b, c, d, out_valid} !== {8'h00, 8'h00, 8'hA5, 8'h00, 4'b0100}) begin
            failures++;
            $display("FAIL wide_word got=%h/%h/%h/%h/%b exp=00/00/a5/00/0100", a, b, c, d, out_valid);
        end
        din = 8'h3C;
        sel = 2'b11;
        step();
        checks++;
        if ({a, b, c, d, out_valid} !== {8'h00, 8'h00, 8'h00, 8'h3C, 4'b1000}) begin
            failures++;
            $display("FAIL back_to_back got=%h/%h/%h/%h/%b exp=00/00/00/3c/1000", a, b, c, d, out_valid);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stats();
        logic [CW-1:0] exp_d;
        apply_reset();
        in_valid = 1'b1;
        din = 8'h11;
        sel = 2'b11;
        for (int i = 1; i <= 5; i++) begin
            step();
            exp_d = STATS ? ((i > 3) ? 2'd3 : 2'(i)) : 2'd0;
            checks++;
            if (hit_cnt_d !== exp_d) begin
                failures++;
                $display("FAIL stats_count n=%0d got=%0d exp=%0d", i, hit_cnt_d, exp_d);
            end
        end
        checks++;
        if ({hit_cnt_a, hit_cnt_b, hit_cnt_c} !== '0) begin
            failures++;
            $display("FAIL stats_others got=%0d/%0d/%0d exp=0/0/0", hit_cnt_a, hit_cnt_b, hit_cnt_c);
        end
        clr_stats = 1'b1;
        din = 8'h22;
        step();
        checks++;
        if (hit_cnt_d !== 2'd0) begin
            failures++;
            $display("FAIL stats_clear got=%0d exp=0", hit_cnt_d);
        end
        checks++;
        if ({d, out_valid} !== {8'h22, 4'b1000}) begin
            failures++;
            $display("FAIL stats_clear_data got=%h/%b exp=22/1000", d, out_valid);
        end
        clr_stats = 1'b0;
        sel = 2'b00;
        step();
        checks++;
        if ({hit_cnt_a, hit_cnt_d} !== {(STATS ? 2'd1 : 2'd0), 2'd0}) begin
            failures++;
            $display("FAIL stats_after_clear got=%0d/%0d exp=%0d/0", hit_cnt_a, hit_cnt_d, STATS ? 1 : 0);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        #3;
        test_reset();
        test_route_one();
        test_zero_word();
        test_wide_word();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
